// File: rtl/pipeline_control.sv
// Pipeline hazard/flush/memory-wait controller: combinational stall and flush
// strobes from a four-state FSM, registered redirect, status and counters.
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef OP_LOAD
`define OP_LOAD 5'd0
`endif

module pipeline_control #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dec_valid,
    input  logic                    dec_rs1_used,
    input  logic                    dec_rs2_used,
    input  logic [`REG_ADDR_SIZE:0] dec_rs1,
    input  logic [`REG_ADDR_SIZE:0] dec_rs2,
    input  logic                    ex_valid,
    input  logic [4:0]              ex_opcode,
    input  logic [`REG_ADDR_SIZE:0] ex_rd,
    input  logic                    flush_req,
    input  logic [`ADDR_SIZE:0]     flush_addr,
    input  logic                    halt_in,
    input  logic                    mem_busy,
    output logic                    stall_fetch,
    output logic                    stall_decode,
    output logic                    stall_execute,
    output logic                    flush_fetch,
    output logic                    flush_decode,
    output logic                    redirect_valid,
    output logic [`ADDR_SIZE:0]     redirect_addr,
    output logic                    halted,
    output logic                    mem_timeout_err,
    output logic [2:0]              state,
    output logic [15:0]             stall_count,
    output logic [15:0]             flush_count
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        FLUSH    = 3'd1,
        MEM_WAIT = 3'd2,
        HALT     = 3'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] MEM_LIMIT  = 8'(MEM_TIMEOUT);

    state_t     cur_state, nxt_state;
    logic [3:0] flush_cnt, flush_cnt_nxt;
    logic [7:0] mem_cnt, mem_cnt_nxt;
    logic       load_use, flush_take, timeout_hit;

    assign load_use = ex_valid && (ex_opcode == `OP_LOAD) && (ex_rd != '0) && dec_valid &&
                      ((dec_rs1_used && (dec_rs1 == ex_rd)) ||
                       (dec_rs2_used && (dec_rs2 == ex_rd)));

    always_comb begin
        nxt_state     = cur_state;
        flush_cnt_nxt = flush_cnt;
        mem_cnt_nxt   = mem_cnt;
        flush_take    = 1'b0;
        timeout_hit   = 1'b0;
        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        stall_execute = 1'b0;
        flush_fetch   = 1'b0;
        flush_decode  = 1'b0;
        // Strobes are forced low during reset; the register block handles state.
        if (!reset) begin
            case (cur_state)
                RUN: begin
                    if (halt_in) begin
                        nxt_state = HALT;
                    end else if (mem_busy) begin
                        stall_fetch   = 1'b1;
                        stall_decode  = 1'b1;
                        stall_execute = 1'b1;
                        nxt_state     = MEM_WAIT;
                        mem_cnt_nxt   = '0;
                    end else if (flush_req && ex_valid) begin
                        flush_fetch   = 1'b1;
                        flush_decode  = 1'b1;
                        flush_take    = 1'b1;
                        nxt_state     = FLUSH;
                        flush_cnt_nxt = FLUSH_LOAD;
                    end else if (load_use) begin
                        stall_fetch  = 1'b1;
                        stall_decode = 1'b1;
                    end
                end
                FLUSH: begin
                    flush_fetch  = 1'b1;
                    flush_decode = 1'b1;
                    if (halt_in) begin
                        nxt_state = HALT;
                    end else if (mem_busy) begin
                        stall_fetch   = 1'b1;
                        stall_decode  = 1'b1;
                        stall_execute = 1'b1;
                        nxt_state     = MEM_WAIT;
                        mem_cnt_nxt   = '0;
                    end else if (flush_cnt == '0) begin
                        nxt_state = RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 4'd1;
                    end
                end
                MEM_WAIT: begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    stall_execute = 1'b1;
                    if (halt_in) begin
                        nxt_state = HALT;
                    end else if (!mem_busy) begin
                        nxt_state = RUN;
                    end else if (mem_cnt == MEM_LIMIT) begin
                        timeout_hit = 1'b1;
                        nxt_state   = HALT;
                    end else begin
                        mem_cnt_nxt = mem_cnt + 8'd1;
                    end
                end
                HALT: begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    stall_execute = 1'b1;
                end
                default: nxt_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state       <= RUN;
            flush_cnt       <= '0;
            mem_cnt         <= '0;
            redirect_valid  <= 1'b0;
            redirect_addr   <= '0;
            halted          <= 1'b0;
            mem_timeout_err <= 1'b0;
            stall_count     <= '0;
            flush_count     <= '0;
        end else begin
            cur_state      <= nxt_state;
            flush_cnt      <= flush_cnt_nxt;
            mem_cnt        <= mem_cnt_nxt;
            redirect_valid <= flush_take;
            halted         <= (nxt_state == HALT);
            if (flush_take)
                redirect_addr <= flush_addr;
            if (timeout_hit)
                mem_timeout_err <= 1'b1;
            if (stall_fetch && (stall_count != '1))
                stall_count <= stall_count + 16'd1;
            if (flush_take && (flush_count != '1))
                flush_count <= flush_count + 16'd1;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: a load-use vector table plus hand
// sequences for flush, memory wait, timeout, halt and reset behaviour.
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef OP_LOAD
`define OP_LOAD 5'd0
`endif

module tb_pipeline_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset, dec_valid, dec_rs1_used, dec_rs2_used;
    logic [`REG_ADDR_SIZE:0] dec_rs1, dec_rs2, ex_rd;
    logic                    ex_valid, flush_req, halt_in, mem_busy;
    logic [4:0]              ex_opcode;
    logic [`ADDR_SIZE:0]     flush_addr;

    logic                stall_fetch, stall_decode, stall_execute, flush_fetch, flush_decode;
    logic                redirect_valid, halted, mem_timeout_err;
    logic [`ADDR_SIZE:0] redirect_addr;
    logic [2:0]          state;
    logic [15:0]         stall_count, flush_count;

    logic                stall_fetch_1, stall_decode_1, stall_execute_1, flush_fetch_1, flush_decode_1;
    logic                redirect_valid_1, halted_1, mem_timeout_err_1;
    logic [`ADDR_SIZE:0] redirect_addr_1;
    logic [2:0]          state_1;
    logic [15:0]         stall_count_1, flush_count_1;

    pipeline_control #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) u0 (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1_used(dec_rs1_used),
        .dec_rs2_used(dec_rs2_used), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .flush_req(flush_req), .flush_addr(flush_addr), .halt_in(halt_in), .mem_busy(mem_busy),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
        .flush_fetch(flush_fetch), .flush_decode(flush_decode),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .halted(halted), .mem_timeout_err(mem_timeout_err), .state(state),
        .stall_count(stall_count), .flush_count(flush_count));

    pipeline_control #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(255)) u1 (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1_used(dec_rs1_used),
        .dec_rs2_used(dec_rs2_used), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .flush_req(flush_req), .flush_addr(flush_addr), .halt_in(halt_in), .mem_busy(mem_busy),
        .stall_fetch(stall_fetch_1), .stall_decode(stall_decode_1), .stall_execute(stall_execute_1),
        .flush_fetch(flush_fetch_1), .flush_decode(flush_decode_1),
        .redirect_valid(redirect_valid_1), .redirect_addr(redirect_addr_1),
        .halted(halted_1), .mem_timeout_err(mem_timeout_err_1), .state(state_1),
        .stall_count(stall_count_1), .flush_count(flush_count_1));

    typedef struct {
        logic       dv, r1u, r2u;
        logic [4:0] r1, r2;
        logic       ev;
        logic [4:0] op, rd;
        logic       fr;
        logic       sf, sd, se, ff;
    } vec_t;

    localparam logic [4:0] LD  = `OP_LOAD;
    localparam logic [4:0] ALU = 5'b01100;

    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;
    int   exp_stalls = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1_used = 0; dec_rs2_used = 0; dec_rs1 = '0; dec_rs2 = '0;
        ex_valid = 0; ex_opcode = ALU; ex_rd = '0; flush_req = 0; flush_addr = '0;
        halt_in = 0; mem_busy = 0;
    endtask

    task automatic set_load_use();
        ex_valid = 1; ex_opcode = LD; ex_rd = 5'd5;
        dec_valid = 1; dec_rs2_used = 1; dec_rs2 = 5'd5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        //                dv r1u r2u r1 r2 ev op  rd fr  sf sd se ff
        vecs[0] = '{1, 0, 1, 5'd0, 5'd5, 1, LD,  5'd5, 0, 1, 1, 0, 0};
        vecs[1] = '{1, 0, 1, 5'd0, 5'd0, 1, LD,  5'd0, 0, 0, 0, 0, 0};
        vecs[2] = '{1, 0, 1, 5'd5, 5'd3, 1, LD,  5'd5, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 1, 0, 5'd5, 5'd0, 1, LD,  5'd5, 0, 1, 1, 0, 0};
        vecs[4] = '{1, 1, 1, 5'd5, 5'd5, 1, ALU, 5'd5, 0, 0, 0, 0, 0};
        vecs[5] = '{1, 1, 1, 5'd5, 5'd5, 0, LD,  5'd5, 0, 0, 0, 0, 0};
        vecs[6] = '{0, 1, 1, 5'd5, 5'd5, 1, LD,  5'd5, 0, 0, 0, 0, 0};
        vecs[7] = '{1, 1, 0, 5'd7, 5'd0, 0, LD,  5'd7, 1, 0, 0, 0, 0};

        // Reset: strobes low while asserted, all registered outputs cleared.
        idle();
        reset = 1; mem_busy = 1; set_load_use();
        #1;
        chk("rst_stall_f", {31'd0, stall_fetch}, 0);
        chk("rst_stall_e", {31'd0, stall_execute}, 0);
        chk("rst_flush_f", {31'd0, flush_fetch}, 0);
        tick();
        tick();
        chk("rst_state", {29'd0, state}, 0);
        chk("rst_stall_cnt", {16'd0, stall_count}, 0);
        chk("rst_flush_cnt", {16'd0, flush_count}, 0);
        chk("rst_redir_addr", redirect_addr, 0);
        chk("rst_redir_v", {31'd0, redirect_valid}, 0);
        chk("rst_err", {31'd0, mem_timeout_err}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        reset = 0;
        idle();
        tick();

        // Load-use vector table (all in RUN).
        for (int i = 0; i < 8; i++) begin
            dec_valid = vecs[i].dv; dec_rs1_used = vecs[i].r1u; dec_rs2_used = vecs[i].r2u;
            dec_rs1 = vecs[i].r1; dec_rs2 = vecs[i].r2; ex_valid = vecs[i].ev;
            ex_opcode = vecs[i].op; ex_rd = vecs[i].rd; flush_req = vecs[i].fr;
            #1;
            chk($sformatf("vec%0d_stall_f", i), {31'd0, stall_fetch}, {31'd0, vecs[i].sf});
            chk($sformatf("vec%0d_stall_d", i), {31'd0, stall_decode}, {31'd0, vecs[i].sd});
            chk($sformatf("vec%0d_stall_e", i), {31'd0, stall_execute}, {31'd0, vecs[i].se});
            chk($sformatf("vec%0d_flush_f", i), {31'd0, flush_fetch}, {31'd0, vecs[i].ff});
            exp_stalls += int'(vecs[i].sf);
            tick();
            chk($sformatf("vec%0d_state", i), {29'd0, state}, 0);
        end
        idle();
        #1;
        chk("lu_one_cycle", {31'd0, stall_fetch}, 0);
        chk("lu_stall_cnt", {16'd0, stall_count}, exp_stalls);

        // Flush with simultaneous load-use: flush wins.
        set_load_use();
        flush_req = 1; flush_addr = 32'h40;
        #1;
        chk("fl_req_ff", {31'd0, flush_fetch}, 1);
        chk("fl_req_fd", {31'd0, flush_decode}, 1);
        chk("fl_req_sf", {31'd0, stall_fetch}, 0);
        chk("fl_req_ff1", {31'd0, flush_fetch_1}, 1);
        tick();
        idle();
        #1;
        chk("fl1_state", {29'd0, state}, 1);
        chk("fl1_redir_v", {31'd0, redirect_valid}, 1);
        chk("fl1_redir_a", redirect_addr, 32'h40);
        chk("fl1_ff", {31'd0, flush_fetch}, 1);
        chk("fl1_cnt", {16'd0, flush_count}, 1);
        chk("fl1_state_u1", {29'd0, state_1}, 1);
        chk("fl1_redir_v_u1", {31'd0, redirect_valid_1}, 1);
        tick();
        chk("fl2_state", {29'd0, state}, 1);
        chk("fl2_ff", {31'd0, flush_decode}, 1);
        chk("fl2_redir_v", {31'd0, redirect_valid}, 0);
        chk("fl2_redir_a", redirect_addr, 32'h40);
        chk("fl2_state_u1", {29'd0, state_1}, 0);
        chk("fl2_ff_u1", {31'd0, flush_fetch_1}, 0);
        tick();
        chk("fl3_state", {29'd0, state}, 0);
        chk("fl3_ff", {31'd0, flush_fetch}, 0);

        // mem_busy for 3 cycles -> 4 stall cycles.
        mem_busy = 1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_busy = 0;
            #1;
            chk($sformatf("mw%0d_sf", c), {31'd0, stall_fetch}, 1);
            chk($sformatf("mw%0d_se", c), {31'd0, stall_execute}, 1);
            chk($sformatf("mw%0d_ff", c), {31'd0, flush_fetch}, 0);
            tick();
        end
        exp_stalls += 4;
        chk("mw_back_run", {29'd0, state}, 0);
        chk("mw_stall_cnt", {16'd0, stall_count}, exp_stalls);

        // mem_busy during FLUSH abandons the flush.
        ex_valid = 1; flush_req = 1; flush_addr = 32'h100;
        tick();
        idle();
        mem_busy = 1;
        #1;
        chk("fmw_se", {31'd0, stall_execute}, 1);
        tick();
        chk("fmw_state", {29'd0, state}, 2);
        chk("fmw_ff", {31'd0, flush_fetch}, 0);
        chk("fmw_state_u1", {29'd0, state_1}, 2);
        mem_busy = 0;
        tick();
        chk("fmw_run", {29'd0, state}, 0);
        chk("fmw_ff_run", {31'd0, flush_fetch}, 0);
        chk("fmw_fcnt", {16'd0, flush_count}, 2);
        exp_stalls += 2;
        chk("fmw_scnt", {16'd0, stall_count}, exp_stalls);

        // Memory timeout (u0 limit 4).
        mem_busy = 1;
        tick(); tick(); tick();
        chk("to_early_err", {31'd0, mem_timeout_err}, 0);
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (halted) done = 1;
            else tick();
        end
        chk("to_reached", {31'd0, done}, 1);
        chk("to_err", {31'd0, mem_timeout_err}, 1);
        chk("to_state", {29'd0, state}, 3);
        chk("to_sf", {31'd0, stall_fetch}, 1);
        chk("to_err_u1", {31'd0, mem_timeout_err_1}, 0);
        mem_busy = 0;
        tick();
        chk("halt_terminal", {29'd0, state}, 3);
        chk("halt_err_sticky", {31'd0, mem_timeout_err}, 1);
        chk("u1_back_run", {29'd0, state_1}, 0);
        reset = 1;
        #1;
        chk("rst_in_halt_sf", {31'd0, stall_fetch}, 0);
        tick();
        reset = 0;
        chk("rst_halt_state", {29'd0, state}, 0);
        chk("rst_halt_err", {31'd0, mem_timeout_err}, 0);

        // halt_in beats flush_req.
        ex_valid = 1; flush_req = 1; halt_in = 1; flush_addr = 32'h200;
        #1;
        chk("hf_ff", {31'd0, flush_fetch}, 0);
        tick();
        idle();
        chk("hf_state", {29'd0, state}, 3);
        chk("hf_halted", {31'd0, halted}, 1);
        chk("hf_redir_v", {31'd0, redirect_valid}, 0);
        chk("hf_redir_a", redirect_addr, 0);
        chk("hf_fcnt", {16'd0, flush_count}, 0);
        ex_valid = 1; flush_req = 1;
        tick();
        idle();
        chk("hf_still_halt", {29'd0, state}, 3);
        chk("hf_redir_v2", {31'd0, redirect_valid}, 0);
        reset = 1;
        tick();
        reset = 0;
        chk("hr_state", {29'd0, state}, 0);
        chk("hr_halted", {31'd0, halted}, 0);
        chk("hr_scnt", {16'd0, stall_count}, 0);
        chk("hr_sf", {31'd0, stall_fetch}, 0);

        // Reset in the middle of FLUSH.
        ex_valid = 1; flush_req = 1; flush_addr = 32'h300;
        tick();
        idle();
        chk("rf_in_flush", {29'd0, state}, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("rf_state", {29'd0, state}, 0);
        chk("rf_redir_v", {31'd0, redirect_valid}, 0);
        chk("rf_redir_a", redirect_addr, 0);
        chk("rf_fcnt", {16'd0, flush_count}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
